// File: rtl/foc_pkg.sv
// Shared constants, state encoding and saturation helper for the FOC datapath.
package foc_pkg;

  localparam int unsigned W_I   = 12;          // signed current width
  localparam int unsigned W_T   = 12;          // signed sin/cos width
  localparam int unsigned FRAC  = 10;          // fractional bits of sin/cos
  localparam int unsigned W_P   = W_I + W_T;   // full product width
  localparam int unsigned W_ACC = W_P + 1;     // sum of two products, or a negated product

  // Q1.10 unity; sin/cos never exceed this magnitude.
  localparam int signed Q_UNITY = (2 ** FRAC) - 1;

  localparam int signed I_MAX = (2 ** (W_I - 1)) - 1;
  localparam int signed I_MIN = -(2 ** (W_I - 1));

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StM0   = 3'd1,
    StM1   = 3'd2,
    StM2   = 3'd3,
    StM3   = 3'd4,
    StOut  = 3'd5
  } park_state_e;

  // Clamp an accumulator-width value into the signed current range.
  function automatic logic signed [W_I-1:0] sat_i(input logic signed [W_ACC-1:0] v);
    if (v > W_ACC'(I_MAX)) begin
      return W_I'(I_MAX);
    end else if (v < W_ACC'(I_MIN)) begin
      return W_I'(I_MIN);
    end else begin
      return v[W_I-1:0];
    end
  endfunction

endpackage

// File: rtl/park_mac.sv
// Shared signed multiplier with operand select, optional negation and
// load/accumulate into one of two accumulators (d or q).
module park_mac
  import foc_pkg::*;
(
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iEn,
  input  logic                    iSelBeta,  // 0: alpha, 1: beta
  input  logic                    iSelSin,   // 0: cos, 1: sin
  input  logic                    iNeg,      // negate the product before use
  input  logic                    iAccum,    // 0: load, 1: add to accumulator
  input  logic                    iDstQ,     // 0: d accumulator, 1: q accumulator
  input  logic signed [W_I-1:0]   iAlpha,
  input  logic signed [W_I-1:0]   iBeta,
  input  logic signed [W_T-1:0]   iSin,
  input  logic signed [W_T-1:0]   iCos,
  output logic signed [W_ACC-1:0] oAccD,
  output logic signed [W_ACC-1:0] oAccQ
);

  logic signed [W_I-1:0]   op_i;
  logic signed [W_T-1:0]   op_t;
  logic signed [W_P-1:0]   prod;
  logic signed [W_ACC-1:0] term;
  logic signed [W_ACC-1:0] base;
  logic signed [W_ACC-1:0] sum;

  // Operand select, product, and next accumulator value.
  always_comb begin
    op_i = iSelBeta ? iBeta : iAlpha;
    op_t = iSelSin ? iSin : iCos;
    prod = op_i * op_t;
    // Sign-extend before negating so -(-2048*-1023)... stays representable.
    term = {prod[W_P-1], prod};
    if (iNeg) begin
      term = -term;
    end
    base = iDstQ ? oAccQ : oAccD;
    sum  = iAccum ? (base + term) : term;
  end

  // Accumulator registers; only the selected one updates.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oAccD <= '0;
      oAccQ <= '0;
    end else if (iEn) begin
      if (iDstQ) begin
        oAccQ <= sum;
      end else begin
        oAccD <= sum;
      end
    end
  end

endmodule

// File: rtl/park_transform.sv
// Park transform: (Ialpha, Ibeta) -> (Id, Iq) using one time-shared multiplier.
//   Id =  a*cos + b*sin
//   Iq = -a*sin + b*cos
// Six cycles per transform: capture, four MAC steps, output.
module park_transform
  import foc_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iP_en,
  input  logic signed [W_I-1:0] iIalpha,
  input  logic signed [W_I-1:0] iIbeta,
  input  logic signed [W_T-1:0] iSin,
  input  logic signed [W_T-1:0] iCos,
  output logic signed [W_I-1:0] oId,
  output logic signed [W_I-1:0] oIq,
  output logic                  oP_done
);

  park_state_e state_q;
  logic        en_hist_q;

  logic signed [W_I-1:0] alpha_q;
  logic signed [W_I-1:0] beta_q;
  logic signed [W_T-1:0] sin_q;
  logic signed [W_T-1:0] cos_q;

  logic                    mac_en;
  logic                    mac_sel_beta;
  logic                    mac_sel_sin;
  logic                    mac_neg;
  logic                    mac_accum;
  logic                    mac_dst_q;
  logic signed [W_ACC-1:0] acc_d;
  logic signed [W_ACC-1:0] acc_q;
  logic signed [W_ACC-1:0] id_shift;
  logic signed [W_ACC-1:0] iq_shift;

  park_mac u_mac (
    .iClk     (iClk),
    .iRst     (iRst),
    .iEn      (mac_en),
    .iSelBeta (mac_sel_beta),
    .iSelSin  (mac_sel_sin),
    .iNeg     (mac_neg),
    .iAccum   (mac_accum),
    .iDstQ    (mac_dst_q),
    .iAlpha   (alpha_q),
    .iBeta    (beta_q),
    .iSin     (sin_q),
    .iCos     (cos_q),
    .oAccD    (acc_d),
    .oAccQ    (acc_q)
  );

  // MAC step decode from the current state.
  always_comb begin
    mac_en       = 1'b0;
    mac_sel_beta = 1'b0;
    mac_sel_sin  = 1'b0;
    mac_neg      = 1'b0;
    mac_accum    = 1'b0;
    mac_dst_q    = 1'b0;
    case (state_q)
      StM0: begin  // accD = a*cos
        mac_en = 1'b1;
      end
      StM1: begin  // accD += b*sin
        mac_en       = 1'b1;
        mac_sel_beta = 1'b1;
        mac_sel_sin  = 1'b1;
        mac_accum    = 1'b1;
      end
      StM2: begin  // accQ = -(a*sin)
        mac_en      = 1'b1;
        mac_sel_sin = 1'b1;
        mac_neg     = 1'b1;
        mac_dst_q   = 1'b1;
      end
      StM3: begin  // accQ += b*cos
        mac_en       = 1'b1;
        mac_sel_beta = 1'b1;
        mac_accum    = 1'b1;
        mac_dst_q    = 1'b1;
      end
      default: ;
    endcase
  end

  // Drop the Q1.10 fraction with floor truncation.
  always_comb begin
    id_shift = acc_d >>> FRAC;
    iq_shift = acc_q >>> FRAC;
  end

  // Sequencer, input capture and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      en_hist_q <= 1'b0;
      alpha_q   <= '0;
      beta_q    <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      oId       <= '0;
      oIq       <= '0;
      oP_done   <= 1'b0;
    end else begin
      en_hist_q <= iP_en;
      oP_done   <= 1'b0;
      case (state_q)
        StIdle: begin
          // Rising edges seen while busy are dropped, not queued.
          if (iP_en && !en_hist_q) begin
            alpha_q <= iIalpha;
            beta_q  <= iIbeta;
            sin_q   <= iSin;
            cos_q   <= iCos;
            state_q <= StM0;
          end
        end
        StM0:  state_q <= StM1;
        StM1:  state_q <= StM2;
        StM2:  state_q <= StM3;
        StM3:  state_q <= StOut;
        StOut: begin
          oId     <= sat_i(id_shift);
          oIq     <= sat_i(iq_shift);
          oP_done <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_park_transform.sv
// Self-checking bench for park_transform: directed cases from the test plan
// plus randomized transforms checked against an integer arithmetic model.
module tb_park_transform;

  logic               iClk = 1'b0;
  logic               iRst;
  logic               iP_en;
  logic signed [11:0] iIalpha;
  logic signed [11:0] iIbeta;
  logic signed [11:0] iSin;
  logic signed [11:0] iCos;
  logic signed [11:0] oId;
  logic signed [11:0] oIq;
  logic               oP_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 iClk = ~iClk;

  park_transform dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iP_en   (iP_en),
    .iIalpha (iIalpha),
    .iIbeta  (iIbeta),
    .iSin    (iSin),
    .iCos    (iCos),
    .oId     (oId),
    .oIq     (oIq),
    .oP_done (oP_done)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference: rotate by theta in plain integer math, floor-divide by 2^10, clamp.
  task automatic model(input int a, input int b, input int s, input int c,
                       output int d, output int q);
    int rd;
    int rq;
    rd = a * c + b * s;
    rq = b * c - a * s;
    d  = sat12(rd >>> 10);
    q  = sat12(rq >>> 10);
  endtask

  task automatic drive(input int a, input int b, input int s, input int c);
    iIalpha = 12'(a);
    iIbeta  = 12'(b);
    iSin    = 12'(s);
    iCos    = 12'(c);
  endtask

  task automatic drive_random();
    drive(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
          int'($urandom_range(2046)) - 1023, int'($urandom_range(2046)) - 1023);
  endtask

  // One transform from an idle DUT with iP_en low on the previous edge.
  // Checks done timing, result, and that inputs are not used after capture.
  task automatic run_one(input string tag, input int a, input int b, input int s,
                         input int c, input int ed, input int eq);
    drive(a, b, s, c);
    iP_en = 1'b1;
    tick();                                   // edge T: capture
    drive_random();
    chk({tag, "_done_T"}, 32'(oP_done), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk({tag, "_done_early"}, 32'(oP_done), 0);
    end
    tick();                                   // edge T+5
    chk({tag, "_done"}, 32'(oP_done), 1);
    chk({tag, "_id"}, oId, ed);
    chk({tag, "_iq"}, oIq, eq);
    iP_en = 1'b0;
    tick();
    chk({tag, "_done_width"}, 32'(oP_done), 0);
    chk({tag, "_id_hold"}, oId, ed);
  endtask

  initial begin
    int ra, rb, rs, rc, ed, eq, ed2, eq2, cnt;

    iRst  = 1'b1;
    iP_en = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_id", oId, 0);
    chk("rst_iq", oIq, 0);
    chk("rst_done", 32'(oP_done), 0);
    iRst = 1'b0;
    tick();

    // Directed cases with hand-computed results.
    run_one("theta0", 1000, -500, 0, 1023, 999, -500);
    run_one("theta90", 1000, 0, 1023, 0, 0, -1000);
    run_one("sat_pos", 2047, 2047, 1023, 1023, 2047, 0);
    run_one("sat_neg", -2048, -2048, 1023, 1023, -2048, 0);

    // Second edge while busy and input changes after capture.
    drive(700, -300, 400, 900);
    model(700, -300, 400, 900, ed, eq);
    iP_en = 1'b1;
    tick();                                   // T
    iP_en = 1'b0;
    drive_random();
    tick();                                   // T+1
    iP_en = 1'b1;
    drive_random();
    tick();                                   // T+2
    iP_en = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick();
      if (oP_done) begin
        cnt++;
        chk("busy_id", oId, ed);
        chk("busy_iq", oIq, eq);
      end
    end
    chk("busy_done_count", cnt, 1);

    // Enable held high: exactly one run.
    drive(-900, 650, -800, 512);
    model(-900, 650, -800, 512, ed, eq);
    iP_en = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (oP_done) begin
        cnt++;
        chk("held_id", oId, ed);
        chk("held_iq", oIq, eq);
      end
    end
    iP_en = 1'b0;
    repeat (8) begin
      tick();
      if (oP_done) cnt++;
    end
    chk("held_done_count", cnt, 1);

    // Reset during M2, then restart with enable still high.
    run_one("pre_rst", 1500, 1500, 1023, 1023, 2047, 0);
    drive(300, -200, 512, -700);
    iP_en = 1'b1;
    tick();                                   // T: capture
    tick();                                   // M1
    tick();                                   // M2
    iRst = 1'b1;
    tick();
    chk("midrst_id", oId, 0);
    chk("midrst_iq", oIq, 0);
    chk("midrst_done", 32'(oP_done), 0);
    iRst = 1'b0;
    drive(-1200, 800, -300, 950);
    model(-1200, 800, -300, 950, ed, eq);
    tick();                                   // first post-reset edge starts
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (oP_done) cnt++;
    end
    chk("restart_early_done", cnt, 0);
    tick();
    chk("restart_done", 32'(oP_done), 1);
    chk("restart_id", oId, ed);
    chk("restart_iq", oIq, eq);
    iP_en = 1'b0;
    tick();

    // Back-to-back starts at T and T+6.
    drive(1111, -777, 600, -800);
    model(1111, -777, 600, -800, ed, eq);
    iP_en = 1'b1;
    tick();                                   // T
    iP_en = 1'b0;
    drive_random();
    repeat (4) tick();
    tick();                                   // T+5
    chk("b2b_done1", 32'(oP_done), 1);
    chk("b2b_id1", oId, ed);
    chk("b2b_iq1", oIq, eq);
    drive(-1500, -400, -1000, 100);
    model(-1500, -400, -1000, 100, ed2, eq2);
    iP_en = 1'b1;
    tick();                                   // T+6
    chk("b2b_done_gap", 32'(oP_done), 0);
    iP_en = 1'b0;
    drive_random();
    repeat (4) tick();
    tick();                                   // T+11
    chk("b2b_done2", 32'(oP_done), 1);
    chk("b2b_id2", oId, ed2);
    chk("b2b_iq2", oIq, eq2);
    tick();

    // Randomized transforms against the model.
    for (int n = 0; n < 20; n++) begin
      ra = int'($urandom_range(4095)) - 2048;
      rb = int'($urandom_range(4095)) - 2048;
      rs = int'($urandom_range(2046)) - 1023;
      rc = int'($urandom_range(2046)) - 1023;
      model(ra, rb, rs, rc, ed, eq);
      run_one("rand", ra, rb, rs, rc, ed, eq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
